// File: rtl/demux_1x4_deser_pkg.sv
// rtl/demux_1x4_deser_pkg.sv - shared types and constants for the 1:4 deserialising demux
package demux_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SEL_W     = 2;

  localparam logic MODE_AUTO = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } demux_state_t;

endpackage

// File: rtl/demux_1x4_deser_if.sv
// rtl/demux_1x4_deser_if.sv - beat input and frame output handshake bundle
interface demux_1x4_deser_if #(
  parameter int WIDTH = 1
);
  import demux_pkg::*;

  logic [WIDTH-1:0]           in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic                       mode;
  logic [SEL_W-1:0]           sel;
  logic                       flush;
  logic [NUM_SLOTS*WIDTH-1:0] out_data;
  logic [NUM_SLOTS-1:0]       out_mask;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output in_data, in_valid, mode, sel, flush, out_ready,
    input  in_ready, out_data, out_mask, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, flush, out_ready,
    output in_ready, out_data, out_mask, out_valid
  );

endinterface

// File: rtl/demux_1x4_deser_decoder_2x4.sv
// rtl/demux_1x4_deser_decoder_2x4.sv - enabled 2-to-4 one-hot decoder for slot write enables
module decoder_2x4
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]     sel,
  input  logic                 en,
  output logic [NUM_SLOTS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      case (sel)
        2'd0:    onehot = 4'b0001;
        2'd1:    onehot = 4'b0010;
        2'd2:    onehot = 4'b0100;
        default: onehot = 4'b1000;
      endcase
    end
  end

endmodule

// File: rtl/demux_1x4_deser.sv
// rtl/demux_1x4_deser.sv - collects four narrow beats into one masked wide frame
module demux_1x4_deser
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  demux_1x4_deser_if.slave   bus
);

  demux_state_t                         state;
  logic [NUM_SLOTS-1:0][WIDTH-1:0]      slots;
  logic [NUM_SLOTS-1:0]                 mask;
  logic [SEL_W-1:0]                     cnt;
  logic                                 frame_mode;
  logic                                 out_valid_q;

  logic                                 active;
  logic                                 handoff;
  logic                                 accept;
  logic [NUM_SLOTS-1:0]                 base_mask;
  logic [SEL_W-1:0]                     base_cnt;
  logic                                 beat_mode;
  logic [SEL_W-1:0]                     target;
  logic [NUM_SLOTS-1:0]                 slot_we;
  logic [NUM_SLOTS-1:0]                 new_mask;
  logic                                 complete;

  // A held frame only blocks intake until the consumer takes it, so a beat
  // can land on the same edge as the handoff.
  assign active  = (state == COLLECT) || bus.out_ready;
  assign handoff = (state == FULL) && bus.out_ready;
  assign accept  = bus.in_valid && bus.in_ready;

  assign bus.in_ready = !reset && active;

  // The frame being handed off contributes nothing to the frame that follows.
  assign base_mask = handoff ? '0 : mask;
  assign base_cnt  = handoff ? '0 : cnt;
  assign beat_mode = (base_mask == '0) ? bus.mode : frame_mode;
  assign target    = (beat_mode == MODE_AUTO) ? base_cnt : bus.sel;

  decoder_2x4 u_decoder (
    .sel    (target),
    .en     (accept),
    .onehot (slot_we)
  );

  assign new_mask = base_mask | slot_we;

  always_comb begin
    complete = 1'b0;
    if (accept && (beat_mode == MODE_AUTO) && (target == SEL_W'(NUM_SLOTS - 1)))
      complete = 1'b1;
    if (accept && (beat_mode == MODE_ADDR) && (new_mask == '1))
      complete = 1'b1;
    if (active && bus.flush && (new_mask != '0))
      complete = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      slots       <= '0;
      mask        <= '0;
      cnt         <= '0;
      frame_mode  <= MODE_AUTO;
      out_valid_q <= 1'b0;
    end else if (active) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (slot_we[k])
          slots[k] <= bus.in_data;
        else if (handoff)
          slots[k] <= '0;
      end
      mask <= new_mask;
      if (accept) begin
        frame_mode <= beat_mode;
        cnt        <= (beat_mode == MODE_AUTO) ? base_cnt + SEL_W'(1) : base_cnt;
      end else begin
        cnt <= base_cnt;
      end
      state       <= complete ? FULL : COLLECT;
      out_valid_q <= complete;
    end
  end

  assign bus.out_data  = slots;
  assign bus.out_mask  = mask;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_demux_1x4_deser.sv
// tb/tb_demux_1x4_deser.sv - vector table, corner sequences and randomized model check
module tb_demux_1x4_deser;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  demux_1x4_deser_if #(.WIDTH(8)) bus ();

  demux_1x4_deser #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  d;
    logic        md;
    logic [1:0]  s;
    logic        fl;
    logic        ordy;
    logic        exp_v;
    logic [3:0]  exp_m;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vt[$];

  // reference model state
  bit        m_full;
  bit [7:0]  m_slots[4];
  bit [3:0]  m_mask;
  int        m_cnt;
  bit        m_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic [7:0] d, input logic md,
                       input logic [1:0] s, input logic fl, input logic ordy);
    bus.in_valid  = vld;
    bus.in_data   = d;
    bus.mode      = md;
    bus.sel       = s;
    bus.flush     = fl;
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [3:0] m, input logic [31:0] d);
    chk({name, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({name, ".mask"},  32'(bus.out_mask),  32'(m));
    chk({name, ".data"},  bus.out_data,       d);
  endtask

  function automatic vec_t mk(logic vld, logic [7:0] d, logic md, logic [1:0] s, logic fl,
                              logic ordy, logic ev, logic [3:0] em, logic [31:0] ed);
    vec_t v;
    v.vld = vld; v.d = d; v.md = md; v.s = s; v.fl = fl; v.ordy = ordy;
    v.exp_v = ev; v.exp_m = em; v.exp_d = ed;
    return v;
  endfunction

  function automatic void model_clear();
    m_full = 0;
    m_mask = 0;
    m_cnt  = 0;
    for (int k = 0; k < 4; k++) m_slots[k] = 0;
  endfunction

  // One clock edge of the frame collector, described by its frame rules.
  function automatic void model_step(bit vld, bit [7:0] d, bit md, bit [1:0] s, bit fl, bit ordy);
    bit may_take;
    bit done;
    int t;
    may_take = !m_full || ordy;
    if (!may_take) return;
    if (m_full) begin
      model_clear();
      m_mode = m_mode;
    end
    done = 0;
    if (vld) begin
      if (m_mask == 0) m_mode = md;
      t = m_mode ? int'(s) : m_cnt;
      m_slots[t] = d;
      if (!m_mode) begin
        m_cnt = (m_cnt + 1) % 4;
        if (t == 3) done = 1;
      end else if (m_mask[t] == 0 && (m_mask | (4'b1 << t)) == 4'hF) begin
        done = 1;
      end
      m_mask[t] = 1;
    end
    if (fl && m_mask != 0) done = 1;
    if (done) m_full = 1;
  endfunction

  initial begin
    logic [31:0] held;

    reset = 1'b1;
    drive(1, 8'hFF, 0, 0, 0, 1);
    #1;
    chk("reset.in_ready", 32'(bus.in_ready), 0);
    tick();
    tick();
    chk_out("reset", 0, 4'h0, 32'h0);
    chk("reset.in_ready_held", 32'(bus.in_ready), 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 1);

    // auto frame, then valid drops after handoff
    vt.push_back(mk(1, 8'h11, 0, 0, 0, 1, 0, 4'h1, 32'h00000011));
    vt.push_back(mk(1, 8'h22, 0, 0, 0, 1, 0, 4'h3, 32'h00002211));
    vt.push_back(mk(1, 8'h33, 0, 0, 0, 1, 0, 4'h7, 32'h00332211));
    vt.push_back(mk(1, 8'h44, 0, 0, 0, 1, 1, 4'hF, 32'h44332211));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 4'h0, 32'h00000000));
    // addressed with a repeated slot
    vt.push_back(mk(1, 8'hA1, 1, 3, 0, 1, 0, 4'h8, 32'hA1000000));
    vt.push_back(mk(1, 8'hB2, 1, 1, 0, 1, 0, 4'hA, 32'hA100B200));
    vt.push_back(mk(1, 8'hC3, 1, 1, 0, 1, 0, 4'hA, 32'hA100C300));
    vt.push_back(mk(1, 8'hD4, 1, 0, 0, 1, 0, 4'hB, 32'hA100C3D4));
    vt.push_back(mk(1, 8'hE5, 1, 2, 0, 1, 1, 4'hF, 32'hA1E5C3D4));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 4'hF, 32'hA1E5C3D4));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 4'h0, 32'h00000000));
    // partial addressed frame closed by flush; flush while FULL ignored
    vt.push_back(mk(1, 8'h10, 1, 0, 0, 1, 0, 4'h1, 32'h00000010));
    vt.push_back(mk(1, 8'h30, 1, 2, 0, 1, 0, 4'h5, 32'h00300010));
    vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 4'h5, 32'h00300010));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 4'h5, 32'h00300010));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 4'h0, 32'h00000000));
    // mode toggled mid-frame is ignored
    vt.push_back(mk(1, 8'h01, 0, 0, 0, 1, 0, 4'h1, 32'h00000001));
    vt.push_back(mk(1, 8'h02, 1, 0, 0, 1, 0, 4'h3, 32'h00000201));
    vt.push_back(mk(1, 8'h03, 1, 0, 0, 1, 0, 4'h7, 32'h00030201));
    vt.push_back(mk(1, 8'h04, 1, 0, 0, 1, 1, 4'hF, 32'h04030201));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 4'h0, 32'h00000000));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].vld, vt[i].d, vt[i].md, vt[i].s, vt[i].fl, vt[i].ordy);
      tick();
      chk_out($sformatf("vec%0d", i), vt[i].exp_v, vt[i].exp_m, vt[i].exp_d);
    end

    // back-pressure: FULL frame held for 10 cycles
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'(i + 1), 0, 0, 0, 0);
      tick();
    end
    chk_out("bp.full", 1, 4'hF, 32'h04030201);
    held = bus.out_data;
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'h99, 0, 0, 0, 0);
      #1;
      chk($sformatf("bp.in_ready%0d", i), 32'(bus.in_ready), 0);
      tick();
      chk($sformatf("bp.stable%0d", i), bus.out_data, held);
    end
    drive(1, 8'h55, 0, 0, 0, 1);
    #1;
    chk("bp.in_ready_release", 32'(bus.in_ready), 1);
    tick();
    chk_out("bp.handoff_beat", 0, 4'h1, 32'h00000055);
    drive(1, 8'h66, 0, 0, 0, 1);
    tick();
    chk_out("bp.second_beat", 0, 4'h3, 32'h00006655);

    // reset mid-frame after two auto beats
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    tick();
    reset = 1'b0;
    chk_out("midreset", 0, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'(8'h0A + i), 0, 0, 0, 1);
      tick();
    end
    chk_out("midreset.frame", 1, 4'hF, 32'h0D0C0B0A);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk_out("midreset.drain", 0, 4'h0, 32'h0);

    // randomized run against the frame model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    m_mode = 0;
    for (int i = 0; i < 400; i++) begin
      bit vld, md, fl, ordy, rst;
      bit [7:0] d;
      bit [1:0] s;
      vld  = ($urandom_range(0, 9) < 7);
      d    = 8'($urandom);
      md   = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      if (i < 200) md = ~md;
      s    = 2'($urandom);
      fl   = ($urandom_range(0, 9) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      rst  = ($urandom_range(0, 99) == 0);
      drive(vld, d, md, s, fl, ordy);
      reset = rst;
      #1;
      chk($sformatf("rnd%0d.in_ready", i), 32'(bus.in_ready), 32'(!rst && (!m_full || ordy)));
      tick();
      if (rst) begin
        model_clear();
        m_mode = 0;
      end else begin
        model_step(vld && (!m_full || ordy), d, md, s, fl, ordy);
      end
      chk_out($sformatf("rnd%0d", i), m_full, m_mask,
              {m_slots[3], m_slots[2], m_slots[1], m_slots[0]});
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1x4_deser.md
# demux_1x4_deser

Serial-to-parallel collector, the inverse of the 4:1 select path. Accepts one WIDTH-bit beat per handshake and steers it into one of four output slots, either by an internal slot counter (auto mode) or by an explicit 2-bit select (addressed mode). A completed frame of four slots is presented on a valid/ready output with a slot mask. It feeds wide datapath registers from narrow sources, such as bus bytes into a word or serial bits into a nibble.

## Interface
- WIDTH, default 1: bits per slot.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  beat payload.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- mode  in  1  0 = auto (counter-steered), 1 = addressed (sel-steered); latched on the first beat of a frame.
- sel  in  2  target slot in addressed mode; ignored in auto mode.
- flush  in  1  close a partial frame (addressed or auto).
- out_data  out  4*WIDTH  slot k occupies bits [k*WIDTH +: WIDTH].
- out_mask  out  4  bit k = slot k written in this frame.
- out_valid  out  1  frame available.
- out_ready  in  1  frame consumed when out_valid && out_ready.

## Operation
- States: COLLECT and FULL.
- Reset values:
  - state COLLECT, all slots 0, out_mask 0, slot counter 0.
  - out_valid 0, frame mode 0.
  - in_ready 0 while reset is high.
- in_ready = !reset && (state == COLLECT || out_ready).
- Accepted beat:
  - Target slot t is the counter in auto mode or sel in addressed mode.
  - Slot t is written with in_data and out_mask[t] is set.
  - Auto mode: the counter increments and wraps 3→0.
- Frame mode latches from mode on the beat that finds out_mask == 0. The mode input is ignored for the rest of the frame.
- Completion, which moves the block to FULL:
  - Auto mode: the beat written to slot 3.
  - Addressed mode: out_mask becomes 4'hF.
  - Either mode: flush with a non-empty mask after the update. A beat in the same cycle is included.
- Flush with an empty mask, including flush during FULL, is ignored.
- Addressed mode, repeated sel: the slot is overwritten, the mask is unchanged, and no completion occurs.
- FULL:
  - out_valid = 1; out_data and out_mask are held stable.
  - out_ready without a beat: slots clear to 0, mask and counter clear to 0, state returns to COLLECT.
  - out_ready with a beat in the same cycle: the frame is handed off. Slots clear, then the beat starts a new frame: slot written, mask set to that single bit, mode latched, counter = 1 in auto mode. State COLLECT, or FULL if that beat itself completes the frame (flush, or WIDTH-independent single-beat completion via flush).
- Slots not written in a frame read as 0.
- Reset mid-frame or mid-FULL discards all content with no output.

## Timing
- Beat accepted at edge N that completes a frame: out_valid is high after edge N (visible in cycle N+1).
- Throughput is one beat per cycle, with no bubble at frame boundaries when out_ready is held high.
- out_valid deasserts the cycle after the out_ready handshake unless a new frame completes on that same edge.
- No combinational path from in_data to outputs. in_ready depends combinationally on out_ready only.

## Structure
- Package demux_pkg:
  - enum demux_state_t {COLLECT, FULL}
  - localparam NUM_SLOTS = 4
  - localparam SEL_W = 2
  - mode constants MODE_AUTO = 1'b0, MODE_ADDR = 1'b1.
- Sub-module decoder_2x4 (in: sel[1:0] and en; out: 4-bit one-hot) generates the slot write enables. It is the direct dual of the 4:1 select tree.
- Top level: slot registers, mask, counter, state register, handshake logic.

## Test plan
- Auto mode, WIDTH=8, out_ready=1, beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles → one cycle after the 4th beat, out_data=0x44332211, out_mask=4'hF, out_valid=1 for exactly one cycle.
- Addressed mode, sel 3, 1, 1, 0, 2 with data A, B, C, D, E → completion on E only; slot1 = C; mask goes 8, A, A, B, F.
- Addressed mode, beats to slots 0 and 2, then flush with no beat → out_mask=4'h5, slots 1 and 3 = 0. A flush in the following cycle while FULL is ignored.
- Back-pressure: out_ready=0 while FULL → in_ready=0, out_data stable for 10 cycles. Then out_ready=1 together with in_valid → handoff and new-frame first beat land on the same edge, and the new mask is a single bit.
- Reset asserted after 2 auto-mode beats → after reset, out_valid=0, mask=0, counter=0. The next 4 beats form a frame starting at slot 0.
- Mode toggled mid-frame (auto frame started, mode=1 on beats 2–4) → frame stays in auto mode and completes at slot 3.
